// File: rtl/uncache_bridge.sv
// uncache_bridge: turns the core's single-beat data_sram access into one req/addr_ok/data_ok
// bus transaction, stalling the core until the response (or a watchdog timeout) arrives.
module uncache_bridge #(
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_uncache,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t             state;
  logic [3:0]         we_q;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         size_d;
  logic               rd, resp, tmo;
  assign size_d = (data_sram_we == 4'd0) ? 2'd2 :
                  (data_sram_we == 4'b0001 || data_sram_we == 4'b0010 ||
                   data_sram_we == 4'b0100 || data_sram_we == 4'b1000) ? 2'd0 :
                  (data_sram_we == 4'b0011 || data_sram_we == 4'b1100) ? 2'd1 : 2'd2;
  assign rd   = we_q == 4'd0;
  // a response only counts once the request has been accepted on the bus
  assign resp = mem_data_ok && (state == WAIT || (state == REQ && mem_addr_ok));
  assign tmo  = cnt == CNT_W'(TIMEOUT_CYC - 1);
  assign mem_req          = state == REQ;
  assign mem_wr           = |we_q;
  assign mem_wstrb        = we_q;
  assign stallreq_uncache = state == REQ || state == WAIT || (state == IDLE && data_sram_en);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      we_q            <= '0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_size        <= '0;
      cnt             <= '0;
      data_sram_rdata <= '0;
      bus_err         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (data_sram_en) begin
          we_q      <= data_sram_we;
          mem_addr  <= data_sram_addr;
          mem_wdata <= data_sram_wdata;
          mem_size  <= size_d;
          cnt       <= '0;
          state     <= REQ;
        end
        REQ, WAIT: begin
          cnt <= cnt + 1'b1;
          if (resp) begin
            if (rd) data_sram_rdata <= mem_rdata;
            state <= DONE;
          end else if (tmo) begin
            bus_err <= 1'b1;
            if (rd) data_sram_rdata <= 32'hDEAD_BEEF;
            state <= DONE;
          end else if (state == REQ && mem_addr_ok) begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uncache_bridge.sv
// tb_uncache_bridge: randomized scoreboard bench with a delay-programmable bus responder.
module tb_uncache_bridge;
  localparam int TO = 8;
  logic        clk = 0, reset = 1, en = 0;
  logic [3:0]  we = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic        stall, mem_req, mem_wr, mem_addr_ok, mem_data_ok, bus_err;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  uncache_bridge #(.TIMEOUT_CYC(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_we(we),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .stallreq_uncache(stall), .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .bus_err(bus_err));

  always #5 clk = ~clk;

  typedef struct {bit wr; logic [1:0] size; logic [3:0] strb; logic [31:0] addr, wdata;} bus_t;
  bus_t        req_q[$];
  logic [31:0] cmp_q[$];
  int          checks = 0, errors = 0, hs_cnt = 0, issued = 0;
  int          a_dly = 0, d_dly = 0;
  bit          drop = 0, stray = 1;
  logic [31:0] salt = 0, model_rd = 0;
  logic        model_err = 0;

  function automatic logic [31:0] f(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic [1:0] size_of(logic [3:0] w);
    if (w == 0) return 2;
    if ($countones(w) == 1) return 0;
    if (w == 4'b0011 || w == 4'b1100) return 1;
    return 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // bus responder: addr_ok after a_dly REQ cycles, data_ok d_dly cycles later, stray data_ok otherwise
  initial begin
    int rc, pend;
    logic [31:0] pa;
    rc = 0; pend = 0; pa = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = $urandom;
      if (reset) begin
        rc = 0; pend = 0;
      end else if (mem_req) begin
        if (rc == a_dly) begin
          mem_addr_ok = 1; rc = 0;
          if (!drop && d_dly == 0) begin mem_data_ok = 1; mem_rdata = f(mem_addr); end
          else if (!drop) begin pend = d_dly; pa = mem_addr; end
        end else begin
          rc++;
          mem_data_ok = stray && $urandom_range(0, 2) == 0;
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin mem_data_ok = 1; mem_rdata = f(pa); end
      end else begin
        mem_data_ok = stray && $urandom_range(0, 2) == 0;
      end
    end
  end

  // bus-side monitor: every REQ cycle must present the queued request; pop on handshake
  initial begin
    bus_t e;
    forever begin
      @(negedge clk); #1;
      if (!reset && mem_req) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_req: unexpected request addr %h", mem_addr);
        end else begin
          e = req_q[0];
          chk("mem_wr", 32'(mem_wr), 32'(e.wr));
          chk("mem_size", 32'(mem_size), 32'(e.size));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
          chk("mem_addr", mem_addr, e.addr);
          if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
          if (mem_addr_ok) begin void'(req_q.pop_front()); hs_cnt++; end
        end
      end
    end
  end

  // core-side monitor: en high with stall low is the completion cycle
  initial forever begin
    @(negedge clk); #1;
    if (!reset && en && !stall) begin
      if (cmp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL completion: unexpected, rdata %h", rdata);
      end else chk("rdata", rdata, cmp_q.pop_front());
    end
  end

  task automatic issue(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input int ad, input int dd, input bit dr);
    bus_t e;
    int n, exp_stall;
    logic [31:0] prev;
    prev = model_rd; n = 0;
    a_dly = ad; d_dly = dd; drop = dr;
    e.wr = w != 0; e.size = size_of(w); e.strb = w; e.addr = a; e.wdata = d;
    req_q.push_back(e);
    if (w == 0) model_rd = dr ? 32'hDEAD_BEEF : f(a);
    if (dr) model_err = 1;
    cmp_q.push_back(model_rd);
    exp_stall = dr ? TO + 1 : ad + dd + 2;
    issued++;
    we = w; addr = a; wdata = d; en = 1;
    #1;
    while (stall && n < 40) begin
      chk("rdata_hold", rdata, prev);
      n++;
      @(negedge clk); #2;
    end
    if (n >= 40) begin checks++; errors++; $display("FAIL stall_timeout: stall never released"); end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    chk("bus_err", 32'(bus_err), 32'(model_err));
    @(negedge clk); #2;
  endtask

  task automatic idle(input int g);
    en = 0;
    repeat (g) begin @(negedge clk); #2; end
  endtask

  initial begin
    logic [3:0] wes [14];
    wes = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5, 4'h6, 4'h9, 4'h7};
    salt = $urandom;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_mem_size", 32'(mem_size), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    reset = 0;
    @(negedge clk); #2;
    issue(4'h0, 32'hBFAF_8000, 32'h0, 0, 2, 0);
    idle(1);
    issue(4'b0100, 32'hBFAF_F002, 32'h00AB_0000, 0, 1, 0);
    idle(2);
    issue(4'hF, 32'hBFAF_F010, 32'hCAFE_F00D, 5, 1, 0);
    idle(1);
    issue(4'h0, 32'hBFAF_8004, 32'h0, 0, 0, 0);
    issue(4'h0, 32'hBFAF_8008, 32'h0, 1, 2, 0);
    issue(4'h0, 32'hBFAF_800C, 32'h0, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 60; i++) begin
      issue(wes[$urandom_range(0, 13)], $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
    end
    idle(1);
    // reset in the middle of an outstanding read
    begin
      bus_t e;
      e.wr = 0; e.size = 2; e.strb = 0; e.addr = 32'hBFAF_9000; e.wdata = 0;
      req_q.push_back(e);
      a_dly = 5; d_dly = 1; drop = 0;
      we = 0; addr = 32'hBFAF_9000; en = 1;
      repeat (2) begin @(negedge clk); #2; end
      en = 0; reset = 1;
      #1;
      chk("midrst_mem_req", 32'(mem_req), 0);
      chk("midrst_stall", 32'(stall), 0);
      chk("midrst_rdata", rdata, 0);
      @(negedge clk); #2;
      reset = 0;
      req_q.delete(); cmp_q.delete();
      model_rd = 0; model_err = 0;
      @(negedge clk); #2;
    end
    issue(4'h0, 32'hBFAF_8020, 32'h0, 2, 1, 0);
    idle(2);
    stray = 0;
    issue(4'h0, 32'hBFAF_8030, 32'h0, 0, 0, 1);
    idle(3);
    chk("err_sticky", 32'(bus_err), 1);
    chk("err_rdata", rdata, 32'hDEAD_BEEF);
    stray = 1; drop = 0;
    reset = 1;
    @(negedge clk); #2;
    chk("err_cleared", 32'(bus_err), 0);
    reset = 0; model_rd = 0; model_err = 0;
    @(negedge clk); #2;
    issue(4'h3, 32'hBFAF_F020, 32'h0000_1234, 1, 0, 0);
    idle(3);
    chk("handshakes", 32'(hs_cnt), 32'(issued));
    chk("req_q_empty", 32'(req_q.size()), 0);
    chk("cmp_q_empty", 32'(cmp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/uncache_bridge.md
Name: uncache_bridge

Overview:
- Responder for the core's data_sram interface, targeting uncached accesses (MMIO/confreg).
- Accepts the core's single-beat en/we/addr/wdata request and re-issues it on a two-phase req/addr_ok/data_ok memory bus.
- Asserts stallreq_uncache while the access is outstanding and returns read data registered and stable for the core's MEM2 consumption.
- Sits beside the dcache in the SoC wrapper and drives the core's stallreq_uncache input.

Parameters:
- TIMEOUT_CYC, 1023: cycles an access may stay outstanding before bus_err is raised and the access is aborted.
- CNT_W, 10: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- data_sram_en  input  1  core request valid (level)
- data_sram_we  input  4  byte write strobes; 0 = read
- data_sram_addr  input  32  byte address
- data_sram_wdata  input  32  write data, lane-aligned
- data_sram_rdata  output  32  read data to core
- stallreq_uncache  output  1  stall request to core pipeline control
- mem_req  output  1  bus request
- mem_wr  output  1  1 = write
- mem_size  output  2  0 = byte, 1 = half, 2 = word
- mem_wstrb  output  4  byte strobes (write only)
- mem_addr  output  32  bus address
- mem_wdata  output  32  bus write data
- mem_addr_ok  input  1  request accepted when mem_req & mem_addr_ok
- mem_data_ok  input  1  response beat (read data valid / write done)
- mem_rdata  input  32  bus read data
- bus_err  output  1  sticky timeout flag

Behaviour:
- Reset values (asynchronous): state = IDLE, all outputs 0, watchdog = 0, bus_err = 0, request registers = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If data_sram_en = 1: capture we/addr/wdata into request registers and go to REQ.
  - stallreq_uncache is driven combinationally to 1 in this same cycle, so the core freezes on the edge.
- REQ:
  - mem_req = 1; all mem_* outputs come from the request registers and are stable until accepted.
  - mem_req & mem_addr_ok moves to WAIT.
  - If mem_addr_ok and mem_data_ok arrive in the same cycle: latch data and go directly to DONE.
- WAIT:
  - mem_req = 0.
  - mem_data_ok = 1 moves to DONE; on a read, data_sram_rdata <= mem_rdata at that edge.
  - mem_data_ok while in IDLE, REQ (without addr_ok) or DONE is ignored.
- DONE:
  - stallreq_uncache = 0 so the core advances at this edge; next state is IDLE unconditionally.
  - The still-asserted request from the same instruction is never re-captured.
- stallreq_uncache = 1 in REQ and WAIT, and in IDLE when data_sram_en = 1; 0 otherwise.
- Strobe to size mapping:
  - Read: size 2, wstrb 0000.
  - Write 0001/0010/0100/1000 gives size 0; 0011/1100 gives size 1; 1111 gives size 2.
  - Any other pattern issues size 2 with the strobes passed through unchanged.
  - mem_addr = data_sram_addr unmodified; mem_wdata passes lanes unchanged.
- data_sram_rdata holds its value until the next completed read; writes do not alter it.
- Latency: minimum 3 cycles from en to stall release (IDLE, REQ with addr_ok+data_ok, DONE).
- Watchdog:
  - Counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYC: set bus_err, load data_sram_rdata = 32'hDEAD_BEEF for reads, go to DONE.
  - Late data_ok for the aborted access arriving in IDLE is ignored.
  - bus_err clears only on reset.
- Reset asserted mid-access drops mem_req and stall immediately; no completion is delivered.

Test Plan:
- Word read to 0xBFAF_8000: bus gives addr_ok on the first REQ cycle and data_ok 2 cycles later with 0x1234_5678 -> mem_size = 2, mem_wr = 0, stall high for 4 cycles, rdata = 0x1234_5678 held afterwards.
- Byte write we = 0100, addr 0xBFAF_F002, wdata 0x00AB_0000 -> mem_wr = 1, mem_size = 0, mem_wstrb = 0100, mem_addr = 0xBFAF_F002; previous rdata unchanged.
- Write with addr_ok delayed 5 cycles -> mem_req and mem_addr/mem_wdata stable for all 6 REQ cycles; exactly one mem_req & mem_addr_ok handshake.
- addr_ok and data_ok asserted in the same cycle -> goes directly to DONE; total stall of 2 cycles.
- Back-to-back reads with en held across DONE -> exactly two bus requests; second rdata replaces the first only at its data_ok.
- No data_ok with TIMEOUT_CYC = 8 -> bus_err = 1 after 8 REQ/WAIT cycles, rdata = 0xDEAD_BEEF, stall released; reset clears bus_err.
